mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, the data port, the unified-memory port and the
//   pipeline status signals of the memory port arbiter.
//
//   Signal groups:
//     IF  : if_req_i, if_addr_i -> if_rdata_o, if_ack_o
//     DM  : dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i -> dm_rdata_o, dm_ack_o
//     MEM : mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o <- mem_rdata_i
//     STAT: stall_o, busy_o
//
//   Modports:
//     slave  - the arbiter itself
//     master - the CPU / memory model side driving the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              stall_o;
  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_rdata_o, if_ack_o,
    output dm_rdata_o, dm_ack_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stall_o, busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_rdata_o, if_ack_o,
    input  dm_rdata_o, dm_ack_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stall_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between instruction fetch (IF)
//   and data load/store (DM). Each access is a fixed-latency transaction
//   IDLE -> ISSUE -> WAIT -> RESP; the owner gets a one-cycle ack in RESP.
//   stall_o freezes the pipe while any request is pending and not acked.
//
//   Ports:
//     clk_i, rst_i  - clock, synchronous active-high reset
//     bus (slave)   - IF/DM request ports, memory port, stall_o, busy_o
//
//   Parameters: ADDR_W, DATA_W, MEM_LAT (1..15), STARVE_MAX (1..15)
//
//   Build option: define MEM_ARB_STARVE_EN to let IF win the next grant
//   after STARVE_MAX consecutive DM grants made while IF was waiting.
//   Without it DM has strict priority.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | sample requests, grant and latch the winner
//   ISSUE | mem_en_o high for one cycle with the latched access
//   WAIT  | count to MEM_LAT, then capture read data for the owner
//   RESP  | owner's ack pulses; no grant, next cycle is IDLE
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be within 1..15");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        lat_cnt;
  logic              owner_dm;
  logic              txn_we;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic              busy_q;
  logic              grant_dm;
  logic              grant_if;

`ifdef MEM_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  logic       force_if;

  // Only meaningful when IF is actually waiting; otherwise DM still wins.
  assign force_if = bus.if_req_i && (starve_cnt == 4'(STARVE_MAX));
  assign grant_dm = bus.dm_req_i && !force_if;
`else
  assign grant_dm = bus.dm_req_i;
`endif
  assign grant_if = bus.if_req_i && !grant_dm;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      owner_dm    <= 1'b0;
      txn_we      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt  <= '0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm || grant_if) begin
            owner_dm    <= grant_dm;
            txn_we      <= grant_dm && bus.dm_we_i;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_dm && bus.dm_we_i;
            mem_addr_q  <= grant_dm ? bus.dm_addr_i : bus.if_addr_i;
            mem_wdata_q <= grant_dm ? bus.dm_wdata_i : '0;
            busy_q      <= 1'b1;
            state       <= ISSUE;
`ifdef MEM_ARB_STARVE_EN
            if (grant_if)
              starve_cnt <= '0;
            else if (bus.if_req_i)
              starve_cnt <= starve_cnt + 4'd1;
`endif
          end
        end
        ISSUE: begin
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          lat_cnt     <= 4'd1;
          state       <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 4'(MEM_LAT)) begin
            if (!txn_we) begin
              if (owner_dm)
                dm_rdata_q <= bus.mem_rdata_i;
              else
                if_rdata_q <= bus.mem_rdata_i;
            end
            dm_ack_q <= owner_dm;
            if_ack_q <= !owner_dm;
            state    <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.busy_o      = busy_q;

  // Drops in the ack cycle so the pipe advances exactly once per access.
  assign bus.stall_o = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);

endmodule
